// File: rtl/vending_machine.sv
// vending_machine: coin-accumulating drink vending controller with dispense and change return
module vending_machine #(
   parameter int PRICE_A = 10,
   parameter int PRICE_B = 15,
   parameter int PRICE_C = 20,
   parameter int PRICE_D = 25,
   parameter int CW      = 16,
   parameter int DW      = 6
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [CW-1:0] coin,
   input  logic          X,
   input  logic [DW-1:0] B_drink,
   output logic [CW-1:0] r_Coin,
   output logic [DW-1:0] O_drink,
   output logic [DW-1:0] P_drink
);
   typedef enum logic [1:0] {COLLECT, DISPENSE, CHANGE} state_t;
   state_t        state;
   logic [CW-1:0] credit;
   logic [CW-1:0] sum;
   logic [CW-1:0] price;
   logic [CW-1:0] credit_n;
   logic [CW:0]   raw;
   logic          valid;
   logic          buy;
   logic          afford;
   function automatic logic [DW-1:0] tier(input logic [CW-1:0] c);
      return c >= CW'(PRICE_D) ? DW'(PRICE_D) :
             c >= CW'(PRICE_C) ? DW'(PRICE_C) :
             c >= CW'(PRICE_B) ? DW'(PRICE_B) :
             c >= CW'(PRICE_A) ? DW'(PRICE_A) : '0;
   endfunction
   // saturating credit sum, purchase qualification and next-credit value
   always_comb begin
      raw      = {1'b0, credit} + {1'b0, coin};
      sum      = raw[CW] ? '1 : raw[CW-1:0];
      price    = CW'(B_drink);
      valid    = B_drink == DW'(PRICE_A) || B_drink == DW'(PRICE_B) ||
                 B_drink == DW'(PRICE_C) || B_drink == DW'(PRICE_D);
      buy      = !X && coin == '0 && credit != '0 && valid;
      afford   = credit >= price;
      credit_n = state == COLLECT ? (buy && afford ? credit - price : sum) :
                 state == CHANGE  ? '0 : credit;
   end
   // controller state, credit and registered output pulses
   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= COLLECT;
         credit  <= '0;
         r_Coin  <= '0;
         O_drink <= '0;
         P_drink <= '0;
      end else begin
         credit  <= credit_n;
         P_drink <= tier(credit_n);
         r_Coin  <= '0;
         O_drink <= '0;
         case (state)
            COLLECT: begin
               if (X) begin
                  state  <= CHANGE;
                  r_Coin <= sum;
               end else if (buy && afford) begin
                  state   <= DISPENSE;
                  O_drink <= B_drink;
               end else if (buy) begin
                  state  <= CHANGE;
                  r_Coin <= credit;
               end
            end
            DISPENSE: begin
               state  <= CHANGE;
               r_Coin <= credit;
            end
            default: state <= COLLECT;
         endcase
      end
   end
endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: directed and randomized checks of vending_machine against a transaction model
module tb_vending_machine;
   logic        clock = 0;
   logic        reset = 0;
   logic [15:0] coin = 0;
   logic        X = 0;
   logic [5:0]  B_drink = 0;
   logic [15:0] r_Coin;
   logic [5:0]  O_drink;
   logic [5:0]  P_drink;
   int          passed = 0;
   int          total = 0;
   typedef struct {int o; int r; int c;} ev_t;
   ev_t         pq[$];
   ev_t         ev;
   int          mcredit = 0;
   int          eo = 0;
   int          er = 0;
   int          ep = 0;

   vending_machine dut (
      .clock(clock), .reset(reset), .coin(coin), .X(X), .B_drink(B_drink),
      .r_Coin(r_Coin), .O_drink(O_drink), .P_drink(P_drink)
   );

   always #5 clock = ~clock;

   function automatic int best(input int c);
      return c >= 25 ? 25 : c >= 20 ? 20 : c >= 15 ? 15 : c >= 10 ? 10 : 0;
   endfunction

   function automatic bit is_price(input int b);
      return b == 10 || b == 15 || b == 20 || b == 25;
   endfunction

   // apply one cycle of inputs and advance the transaction-level model
   task automatic step(input logic [15:0] c, input logic x, input logic [5:0] b);
      int s;
      coin = c; X = x; B_drink = b;
      @(posedge clock); #1;
      if (!reset) begin
         mcredit = 0; pq.delete(); eo = 0; er = 0;
      end else if (pq.size() > 0) begin
         ev = pq.pop_front(); eo = ev.o; er = ev.r; mcredit = ev.c;
      end else begin
         s = mcredit + int'(c);
         if (s > 65535) s = 65535;
         eo = 0; er = 0;
         if (x) begin
            er = s; mcredit = s; pq.push_back('{0, 0, 0});
         end else if (c == 0 && mcredit != 0 && is_price(int'(b))) begin
            if (mcredit >= int'(b)) begin
               eo = int'(b); mcredit -= int'(b);
               pq.push_back('{0, mcredit, mcredit});
               pq.push_back('{0, 0, 0});
            end else begin
               er = mcredit; pq.push_back('{0, 0, 0});
            end
         end else mcredit = s;
      end
      ep = best(mcredit);
   endtask

   task automatic test_reset;
      reset = 0;
      step(16'd7, 0, 6'd10);
      step(16'd0, 1, 6'd10);
      total++;
      if ({O_drink, r_Coin, P_drink} !== 28'd0) $display("FAIL reset: O=%0d r=%0d P=%0d want all 0", O_drink, r_Coin, P_drink);
      else passed++;
      reset = 1;
   endtask

   task automatic test_purchase_change;
      step(16'd10, 0, 6'd0);
      step(16'd5, 0, 6'd0);
      total++;
      if (P_drink !== 6'd15) $display("FAIL buy_p: P=%0d want 15", P_drink); else passed++;
      step(16'd0, 0, 6'd10);
      total++;
      if (O_drink !== 6'd10 || r_Coin !== 16'd0) $display("FAIL buy_o: O=%0d r=%0d want 10 0", O_drink, r_Coin); else passed++;
      step(16'd0, 0, 6'd10);
      total++;
      if (O_drink !== 6'd0 || r_Coin !== 16'd5) $display("FAIL buy_r: O=%0d r=%0d want 0 5", O_drink, r_Coin); else passed++;
      step(16'd0, 0, 6'd10);
      total++;
      if ({O_drink, r_Coin, P_drink} !== 28'd0) $display("FAIL buy_idle: O=%0d r=%0d P=%0d want 0", O_drink, r_Coin, P_drink); else passed++;
   endtask

   task automatic test_insufficient;
      step(16'd1, 0, 6'd10);
      total++;
      if (P_drink !== 6'd0 || O_drink !== 6'd0) $display("FAIL insuf_defer: O=%0d P=%0d want 0 0", O_drink, P_drink); else passed++;
      step(16'd0, 0, 6'd10);
      total++;
      if (O_drink !== 6'd0 || r_Coin !== 16'd1) $display("FAIL insuf_r: O=%0d r=%0d want 0 1", O_drink, r_Coin); else passed++;
      step(16'd0, 0, 6'd0);
      total++;
      if ({O_drink, r_Coin, P_drink} !== 28'd0) $display("FAIL insuf_end: O=%0d r=%0d P=%0d want 0", O_drink, r_Coin, P_drink); else passed++;
   endtask

   task automatic test_exact;
      step(16'd10, 0, 6'd0);
      step(16'd5, 0, 6'd0);
      step(16'd10, 0, 6'd0);
      step(16'd0, 0, 6'd25);
      total++;
      if (O_drink !== 6'd25) $display("FAIL exact_o: O=%0d want 25", O_drink); else passed++;
      step(16'd0, 0, 6'd0);
      total++;
      if (O_drink !== 6'd0 || r_Coin !== 16'd0) $display("FAIL exact_r: O=%0d r=%0d want 0 0", O_drink, r_Coin); else passed++;
      step(16'd0, 0, 6'd10);
      total++;
      if ({O_drink, r_Coin, P_drink} !== 28'd0) $display("FAIL exact_end: O=%0d r=%0d P=%0d want 0", O_drink, r_Coin, P_drink); else passed++;
   endtask

   task automatic test_cancel;
      step(16'd10, 0, 6'd0);
      step(16'd1, 0, 6'd0);
      step(16'd5, 0, 6'd0);
      step(16'd5, 0, 6'd0);
      step(16'd5, 0, 6'd0);
      total++;
      if (P_drink !== 6'd25) $display("FAIL cancel_p: P=%0d want 25", P_drink); else passed++;
      step(16'd0, 1, 6'd0);
      total++;
      if (O_drink !== 6'd0 || r_Coin !== 16'd26) $display("FAIL cancel_r: O=%0d r=%0d want 0 26", O_drink, r_Coin); else passed++;
      step(16'd0, 0, 6'd0);
      total++;
      if ({O_drink, r_Coin, P_drink} !== 28'd0) $display("FAIL cancel_end: O=%0d r=%0d P=%0d want 0", O_drink, r_Coin, P_drink); else passed++;
   endtask

   task automatic test_back_to_back;
      step(16'd20, 0, 6'd0);
      step(16'd0, 1, 6'd20);
      total++;
      if (O_drink !== 6'd0 || r_Coin !== 16'd20) $display("FAIL x_wins: O=%0d r=%0d want 0 20", O_drink, r_Coin); else passed++;
      step(16'd0, 0, 6'd0);
   endtask

   task automatic test_reset_mid;
      step(16'd10, 0, 6'd0);
      reset = 0;
      step(16'd0, 0, 6'd10);
      reset = 1;
      total++;
      if ({O_drink, r_Coin, P_drink} !== 28'd0) $display("FAIL rst_mid: O=%0d r=%0d P=%0d want 0", O_drink, r_Coin, P_drink); else passed++;
      step(16'd0, 0, 6'd10);
      total++;
      if ({O_drink, r_Coin, P_drink} !== 28'd0) $display("FAIL rst_after: O=%0d r=%0d P=%0d want 0", O_drink, r_Coin, P_drink); else passed++;
   endtask

   task automatic test_saturation;
      step(16'hFFF0, 0, 6'd0);
      step(16'hFFF0, 0, 6'd0);
      total++;
      if (P_drink !== 6'd25) $display("FAIL sat_p: P=%0d want 25", P_drink); else passed++;
      step(16'd0, 1, 6'd0);
      total++;
      if (r_Coin !== 16'hFFFF) $display("FAIL sat_r: r=%0h want ffff", r_Coin); else passed++;
      step(16'd0, 0, 6'd0);
   endtask

   task automatic test_random;
      logic [5:0] codes [6] = '{6'd10, 6'd15, 6'd20, 6'd25, 6'd0, 6'd13};
      logic [15:0] c;
      for (int i = 0; i < 600; i++) begin
         reset = $urandom_range(0, 59) != 0;
         c = $urandom_range(0, 2) == 0 ? 16'($urandom_range(1, 12)) : 16'd0;
         step(c, $urandom_range(0, 19) == 0, codes[$urandom_range(0, 5)]);
         total++;
         if (O_drink !== 6'(eo) || r_Coin !== 16'(er) || P_drink !== 6'(ep))
            $display("FAIL rand[%0d]: O=%0d r=%0d P=%0d want %0d %0d %0d", i, O_drink, r_Coin, P_drink, eo, er, ep);
         else passed++;
      end
      reset = 1;
   endtask

   initial begin
      test_reset();
      test_purchase_change();
      test_insufficient();
      test_exact();
      test_cancel();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
